// File: rtl/dsp_iterative_divider.sv
// Multi-cycle RV32M divide unit (DIV/DIVU/REM/REMU), restoring shift-subtract, one bit per cycle.
// Optional macro DSP_DIV_FAST_PATH_EN: divide-by-zero and signed overflow bypass the iteration loop.
module dsp_iterative_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  // quo_q holds the shifting dividend; quotient bits enter from the LSB as it drains out the top
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             done_q, done_d;

  logic             signed_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   shifted, trial;
  logic             unused_op;

  // op[1] only selects which result the execute stage consumes; both are always produced
  assign unused_op = op[1];

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & dividend[WIDTH-1];
  assign b_neg     = signed_op & divisor[WIDTH-1];
  // The most negative value maps to itself, which is the correct unsigned magnitude
  assign a_abs     = a_neg ? (~dividend + 1'b1) : dividend;
  assign b_abs     = b_neg ? (~divisor + 1'b1) : divisor;

  // Partial remainder is always below the divisor, so WIDTH+1 bits cover the trial result
  assign shifted   = {rem_q, quo_q[WIDTH-1]};
  assign trial     = shifted - {1'b0, dvs_q};

`ifdef DSP_DIV_FAST_PATH_EN
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};
  logic div_zero, div_ovf;
  assign div_zero = (divisor == '0);
  assign div_ovf  = signed_op && (dividend == MinVal) && (divisor == '1);
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          quo_d     = a_abs;
          dvs_d     = b_abs;
          rem_d     = '0;
          cnt_d     = '0;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          state_d   = StRun;
`ifdef DSP_DIV_FAST_PATH_EN
          // Preload the unsigned-domain result; FIX applies the same sign rules as the loop
          if (div_zero) begin
            quo_d   = '1;
            rem_d   = a_abs;
            state_d = StFix;
          end else if (div_ovf) begin
            quo_d   = MinVal;
            rem_d   = '0;
            state_d = StFix;
          end
`endif
        end
      end

      StRun: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIter) begin
          state_d = StFix;
        end
      end

      StFix: begin
        // Divide-by-zero keeps the all-ones quotient regardless of operand signs
        quotient_d  = (neg_quo_q && (dvs_q != '0)) ? (~quo_q + 1'b1) : quo_q;
        remainder_d = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
        done_d      = 1'b1;
        state_d     = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_dsp_iterative_divider.sv
// Randomized and directed bench for dsp_iterative_divider against a RISC-V arithmetic model.
module tb_dsp_iterative_divider;

  localparam int unsigned W = 32;
  localparam logic [W-1:0] MinVal = 32'h8000_0000;

  logic         clk;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int n_checks = 0;
  int n_errors = 0;

  dsp_iterative_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension semantics straight from the ISA rules
  task automatic ref_div(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r);
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (o[0]) begin
      q = a / b;
      r = a % b;
    end else if (a == MinVal && b == '1) begin
      q = MinVal;
      r = '0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
  endtask

  function automatic int exp_latency(input logic [1:0] o, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    int lat;
    lat = W + 1;
`ifdef DSP_DIV_FAST_PATH_EN
    if (b == 0 || (!o[0] && a == MinVal && b == '1)) lat = 1;
`endif
    return lat;
  endfunction

  // Issue one op and wait for done; b2b issues in the current (done) cycle without waiting.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit b2b, input bit disturb);
    logic [W-1:0] eq, er;
    int n, bc, lat;
    ref_div(o, a, b, eq, er);
    lat = exp_latency(o, a, b);
    if (!b2b) @(negedge clk);
    start = 1'b1; op = o; dividend = a; divisor = b;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    bc = 0;
    @(negedge clk);
    while (!done && n < 100) begin
      if (busy) bc++;
      if (disturb && n == 5) begin
        dividend = $urandom;
        divisor  = $urandom;
        op       = 2'(~o);
        start    = 1'b1;
      end
      if (disturb && n == 6) start = 1'b0;
      @(negedge clk);
      n++;
    end
    check_val({tag, ":done"}, {31'b0, done}, 32'd1);
    check_val({tag, ":lat"}, n, lat);
    check_val({tag, ":busy_cycles"}, bc, lat);
    check_val({tag, ":busy_at_done"}, {31'b0, busy}, 32'd0);
    check_val({tag, ":q"}, quotient, eq);
    check_val({tag, ":r"}, remainder, er);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return MinVal;
      1: return '1;
      2: return '0;
      3: return W'($urandom_range(1, 20));
      4: return -W'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
    #13;
    check_val("reset:busy", {31'b0, busy}, 32'd0);
    check_val("reset:done", {31'b0, done}, 32'd0);
    check_val("reset:q", quotient, 32'd0);
    check_val("reset:r", remainder, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 1'b0, 1'b0);
    run_op("b2b_div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    @(negedge clk);
    check_val("done_pulse", {31'b0, done}, 32'd0);
    check_val("q_held", quotient, 32'hFFFF_FFFD);
    check_val("r_held", remainder, 32'hFFFF_FFFF);
    run_op("remu_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op("div_5_0", 2'b00, 32'd5, 32'd0, 1'b0, 1'b0);
    run_op("div_m5_0", 2'b00, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0);
    run_op("divu_5_0", 2'b01, 32'd5, 32'd0, 1'b0, 1'b0);
    run_op("div_ovf", 2'b00, MinVal, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("divu_ovf", 2'b01, MinVal, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("rem_ovf", 2'b10, MinVal, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("divu_disturb", 2'b01, 32'd1000, 32'd10, 1'b0, 1'b1);
    @(negedge clk);
    check_val("disturb_single_done", {31'b0, done}, 32'd0);
    run_op("b2b_after", 2'b01, 32'd77, 32'd5, 1'b1, 1'b0);

    // Asynchronous reset in the middle of an operation
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'd12345; divisor = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("midrst:busy", {31'b0, busy}, 32'd0);
    check_val("midrst:done", {31'b0, done}, 32'd0);
    check_val("midrst:q", quotient, 32'd0);
    check_val("midrst:r", remainder, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check_val("midrst:no_done", seen, 32'd0);
    run_op("divu_9_4", 2'b01, 32'd9, 32'd4, 1'b0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      run_op($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), pick(), pick(),
             ($urandom_range(0, 3) == 0), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
